// File: rtl/sec08_queues_bypass_queue_pkg.sv
// Width helpers shared by the bypass queue datapath and control.
package sec08_queues_pkg;

    // Pointer width: log2 of the entry count, never narrower than one bit.
    function automatic int unsigned ptr_nbits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Occupancy width: must represent 0..n inclusive.
    function automatic int unsigned cnt_nbits(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sec08_queues_bypass_queue_if.sv
// Producer/consumer val/rdy streams of the bypass queue.
interface sec08_queues_bypass_queue_if #(
    parameter int unsigned p_msg_nbits = 32
) ();
    logic                   istream_val;
    logic                   istream_rdy;
    logic [p_msg_nbits-1:0] istream_msg;
    logic                   ostream_val;
    logic                   ostream_rdy;
    logic [p_msg_nbits-1:0] ostream_msg;

    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );
endinterface

// File: rtl/sec08_queues_bypass_queue_ctrl.sv
// Bypass queue control: pointers, occupancy, handshake and write/bypass decisions.
module sec08_queues_bypass_queue_ctrl
    import sec08_queues_pkg::*;
#(
    parameter int unsigned  p_num_msgs = 2,
    localparam int unsigned PTR_W      = ptr_nbits(p_num_msgs),
    localparam int unsigned CNT_W      = cnt_nbits(p_num_msgs)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    input  logic             ostream_rdy,
    output logic             istream_rdy,
    output logic             ostream_val,
    output logic             wen,
    output logic             bypass_sel,
    output logic [PTR_W-1:0] waddr,
    output logic [PTR_W-1:0] raddr,
    output logic [CNT_W-1:0] num_free_entries
);

    logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
    logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             empty, full, enq, deq, bypass, deq_adv;

    // Handshake and next-state; a bypassed message leaves storage untouched.
    always_comb begin
        enq_ptr_d   = enq_ptr_q;
        deq_ptr_d   = deq_ptr_q;
        count_d     = count_q;

        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(p_num_msgs));
        istream_rdy = !reset && !full;
        ostream_val = !reset && (!empty || istream_val);
        enq         = istream_val && istream_rdy;
        deq         = ostream_val && ostream_rdy;
        bypass      = empty && enq && deq;
        wen         = enq && !bypass;
        deq_adv     = deq && !bypass;

        if (wen) begin
            enq_ptr_d = (enq_ptr_q == PTR_W'(p_num_msgs - 1)) ? '0 : enq_ptr_q + PTR_W'(1);
        end
        if (deq_adv) begin
            deq_ptr_d = (deq_ptr_q == PTR_W'(p_num_msgs - 1)) ? '0 : deq_ptr_q + PTR_W'(1);
        end

        case ({wen, deq_adv})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    assign waddr            = enq_ptr_q;
    assign raddr            = deq_ptr_q;
    assign bypass_sel       = empty;
    assign num_free_entries = CNT_W'(p_num_msgs) - count_q;

endmodule

// File: rtl/sec08_queues_bypass_queue.sv
// Bypass val/rdy queue: an empty queue forwards the input message to the output in the same cycle.
module sec08_queues_bypass_queue
    import sec08_queues_pkg::*;
#(
    parameter int unsigned  p_msg_nbits = 32,
    parameter int unsigned  p_num_msgs  = 2,
    localparam int unsigned CNT_W       = cnt_nbits(p_num_msgs)
) (
    input  logic                  clk,
    input  logic                  reset,
    sec08_queues_bypass_queue_if.slave qif,
    output logic [CNT_W-1:0]      num_free_entries
);

    localparam int unsigned PTR_W = ptr_nbits(p_num_msgs);
    // Storage rounded up to a power of two so pointer indexing is width-exact; extra slots are never written.
    localparam int unsigned DEPTH = 32'(1) << PTR_W;

    logic                   wen;
    logic                   bypass_sel;
    logic [PTR_W-1:0]       waddr, raddr;
    logic [p_msg_nbits-1:0] mem_q [DEPTH];
    logic [p_msg_nbits-1:0] mem_d [DEPTH];

    sec08_queues_bypass_queue_ctrl #(
        .p_num_msgs (p_num_msgs)
    ) u_ctrl (
        .clk              (clk),
        .reset            (reset),
        .istream_val      (qif.istream_val),
        .ostream_rdy      (qif.ostream_rdy),
        .istream_rdy      (qif.istream_rdy),
        .ostream_val      (qif.ostream_val),
        .wen              (wen),
        .bypass_sel       (bypass_sel),
        .waddr            (waddr),
        .raddr            (raddr),
        .num_free_entries (num_free_entries)
    );

    always_comb begin
        mem_d = mem_q;
        if (wen) begin
            mem_d[waddr] = qif.istream_msg;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign qif.ostream_msg = bypass_sel ? qif.istream_msg : mem_q[raddr];

endmodule

// File: tb/tb_sec08_queues_bypass_queue.sv
// Drives bypass queues of depth 1, 2 and 3 side by side and checks them against a queue-based model.
module tb_sec08_queues_bypass_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tb_rst;
    logic        tb_val [3];
    logic [31:0] tb_msg [3];
    logic        tb_rdy [3];

    logic        out_rdy  [3];
    logic        out_val  [3];
    logic [31:0] out_msg  [3];
    logic [31:0] out_free [3];

    logic [0:0] free0;
    logic [1:0] free1, free2;

    sec08_queues_bypass_queue_if #(.p_msg_nbits(32)) if0 ();
    sec08_queues_bypass_queue_if #(.p_msg_nbits(32)) if1 ();
    sec08_queues_bypass_queue_if #(.p_msg_nbits(32)) if2 ();

    sec08_queues_bypass_queue #(.p_msg_nbits(32), .p_num_msgs(1)) u_q1 (
        .clk(clk), .reset(tb_rst), .qif(if0), .num_free_entries(free0));
    sec08_queues_bypass_queue #(.p_msg_nbits(32), .p_num_msgs(2)) u_q2 (
        .clk(clk), .reset(tb_rst), .qif(if1), .num_free_entries(free1));
    sec08_queues_bypass_queue #(.p_msg_nbits(32), .p_num_msgs(3)) u_q3 (
        .clk(clk), .reset(tb_rst), .qif(if2), .num_free_entries(free2));

    assign if0.istream_val = tb_val[0];
    assign if0.istream_msg = tb_msg[0];
    assign if0.ostream_rdy = tb_rdy[0];
    assign if1.istream_val = tb_val[1];
    assign if1.istream_msg = tb_msg[1];
    assign if1.ostream_rdy = tb_rdy[1];
    assign if2.istream_val = tb_val[2];
    assign if2.istream_msg = tb_msg[2];
    assign if2.ostream_rdy = tb_rdy[2];

    assign out_rdy[0]  = if0.istream_rdy;
    assign out_val[0]  = if0.ostream_val;
    assign out_msg[0]  = if0.ostream_msg;
    assign out_free[0] = 32'(free0);
    assign out_rdy[1]  = if1.istream_rdy;
    assign out_val[1]  = if1.ostream_val;
    assign out_msg[1]  = if1.ostream_msg;
    assign out_free[1] = 32'(free1);
    assign out_rdy[2]  = if2.istream_rdy;
    assign out_val[2]  = if2.ostream_val;
    assign out_msg[2]  = if2.ostream_msg;
    assign out_free[2] = 32'(free2);

    // Reference model: each queue's contents in FIFO order, capacity = index + 1.
    logic [31:0] mq [3][$];
    logic        e_rdy [3];
    logic        e_val [3];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          stream_on = 1'b0;
    int          sent [3];
    int          dlv  [3];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[N=%0d] observed=%h expected=%h", tag, idx + 1, obs, exp);
    endtask

    task automatic setin(input logic v, input logic [31:0] m, input logic r);
        for (int i = 0; i < 3; i++) begin
            tb_val[i] = v;
            tb_msg[i] = m;
            tb_rdy[i] = r;
        end
    endtask

    // Compare all three queues against the model mid-cycle.
    task automatic check_now();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz       = mq[i].size();
            e_rdy[i] = !tb_rst && (sz < i + 1);
            e_val[i] = !tb_rst && (sz > 0 || tb_val[i]);
            chk("istream_rdy", i, 32'(out_rdy[i]), 32'(e_rdy[i]));
            chk("ostream_val", i, 32'(out_val[i]), 32'(e_val[i]));
            if (e_val[i]) chk("ostream_msg", i, out_msg[i], (sz > 0) ? mq[i][0] : tb_msg[i]);
            chk("num_free", i, out_free[i], 32'(i + 1 - sz));
            if (stream_on && e_val[i] && tb_rdy[i]) chk("order", i, out_msg[i], 32'(dlv[i]));
        end
    endtask

    // Advance the model across the clock edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int sz;
            bit enq, deq;
            sz  = mq[i].size();
            enq = tb_val[i] && e_rdy[i];
            deq = e_val[i] && tb_rdy[i];
            if (tb_rst) begin
                mq[i].delete();
            end else begin
                if (stream_on) begin
                    if (enq) sent[i]++;
                    if (deq) dlv[i]++;
                end
                if (!(sz == 0 && enq && deq)) begin
                    if (deq) void'(mq[i].pop_front());
                    if (enq) mq[i].push_back(tb_msg[i]);
                end
            end
        end
        #1;
    endtask

    initial begin
        tb_rst = 1'b1;
        setin(1'b1, 32'hDEAD_BEEF, 1'b1);
        check_now();
        chk("rst_rdy", 1, 32'(out_rdy[1]), 32'd0);
        chk("rst_val", 1, 32'(out_val[1]), 32'd0);
        tick();
        tb_rst = 1'b0;
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        chk("post_rst_free", 1, out_free[1], 32'd2);
        chk("post_rst_rdy", 1, 32'(out_rdy[1]), 32'd1);
        tick();

        // Zero-latency bypass through an empty queue
        setin(1'b1, 32'hA5A5_0001, 1'b1);
        check_now();
        chk("byp_val", 1, 32'(out_val[1]), 32'd1);
        chk("byp_msg", 1, out_msg[1], 32'hA5A5_0001);
        chk("byp_free", 1, out_free[1], 32'd2);
        tick();
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        chk("byp_free_after", 1, out_free[1], 32'd2);
        tick();

        // Full queue refuses input even when the consumer is ready
        setin(1'b1, 32'h11, 1'b0); check_now(); tick();
        setin(1'b1, 32'h22, 1'b0); check_now(); tick();
        setin(1'b0, 32'h0, 1'b0);
        check_now();
        chk("full_rdy", 1, 32'(out_rdy[1]), 32'd0);
        chk("full_free", 1, out_free[1], 32'd0);
        tick();
        setin(1'b1, 32'h99, 1'b1);
        check_now();
        chk("full_no_pipe", 1, 32'(out_rdy[1]), 32'd0);
        chk("deq_first", 1, out_msg[1], 32'h11);
        tick();
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        chk("deq_second", 1, out_msg[1], 32'h22);
        tick();
        check_now();
        chk("drained_val", 1, 32'(out_val[1]), 32'd0);
        tick();

        // Simultaneous enq/deq on a non-empty queue
        setin(1'b1, 32'h33, 1'b0); check_now(); tick();
        setin(1'b1, 32'h44, 1'b1);
        check_now();
        chk("hold_msg", 1, out_msg[1], 32'h33);
        tick();
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        chk("hold_free", 1, out_free[1], 32'd1);
        chk("hold_next", 1, out_msg[1], 32'h44);
        tick();
        check_now(); tick();

        // Reset discards stored messages
        setin(1'b1, 32'h55, 1'b0); check_now(); tick();
        setin(1'b1, 32'h66, 1'b0); check_now(); tick();
        tb_rst = 1'b1;
        setin(1'b0, 32'h0, 1'b1);
        check_now(); tick();
        tb_rst = 1'b0;
        check_now();
        chk("rst_mid_val", 1, 32'(out_val[1]), 32'd0);
        chk("rst_mid_free", 1, out_free[1], 32'd2);
        tick();
        setin(1'b1, 32'h77, 1'b1);
        check_now();
        chk("rst_mid_byp", 1, out_msg[1], 32'h77);
        tick();

        // Single-entry queue
        setin(1'b1, 32'h77, 1'b0); check_now(); tick();
        setin(1'b0, 32'h0, 1'b0);
        check_now();
        chk("n1_rdy", 0, 32'(out_rdy[0]), 32'd0);
        chk("n1_free", 0, out_free[0], 32'd0);
        tick();
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        chk("n1_deq", 0, out_msg[0], 32'h77);
        tick();
        setin(1'b1, 32'h88, 1'b1);
        check_now();
        chk("n1_free_after", 0, out_free[0], 32'd1);
        chk("n1_byp", 0, out_msg[0], 32'h88);
        tick();

        // Randomly stalled stream 0..9 into every depth
        tb_rst = 1'b1;
        setin(1'b0, 32'h0, 1'b0);
        check_now(); tick();
        tb_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0;
            dlv[i]  = 0;
        end
        stream_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (dlv[0] == 10 && dlv[1] == 10 && dlv[2] == 10) break;
            for (int i = 0; i < 3; i++) begin
                tb_val[i] = (sent[i] < 10) && ($urandom_range(0, 3) != 0);
                tb_msg[i] = 32'(sent[i]);
                tb_rdy[i] = ($urandom_range(0, 2) != 0);
            end
            check_now();
            tick();
        end
        stream_on = 1'b0;
        for (int i = 0; i < 3; i++) chk("stream_total", i, 32'(dlv[i]), 32'd10);
        setin(1'b0, 32'h0, 1'b1);
        check_now();
        for (int i = 0; i < 3; i++) chk("stream_free", i, out_free[i], 32'(i + 1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
